// File: rtl/song_sequencer.sv
// Song playback sequencer: walks a synchronous song ROM at one of two tempos, shapes each note
// into a sounding HOLD and a silent GAP, and hands the tone generator to the keyboard when idle.
// Define KEY_PREEMPT_EN to let held keys preempt autoplay while busy.
//
// state | meaning
// IDLE  | no song; keyboard drives the tone generator
// FETCH | ROM address presented, beat pulse, tempo sampled
// LOAD  | ROM data valid, latched into the note register
// HOLD  | note sounding (silent for a rest)
// GAP   | silent tail of the note
// PAUSE | song frozen; saved_q remembers where to resume
module song_sequencer #(
    parameter int TICKS_SLOW = 25000000,
    parameter int TICKS_FAST = 10000000,
    parameter int GAP_TICKS  = 1000000,
    parameter int SONG_LEN   = 70,
    parameter int IDX_W      = 7,
    parameter int NOTE_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              tempo,
    input  logic              loop_en,
    input  logic [7:0]        key,
    output logic [IDX_W-1:0]  rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_on,
    output logic              beat_pulse,
    output logic              busy,
    output logic              done
);
    localparam int TICKS_MAX = (TICKS_SLOW > TICKS_FAST) ? TICKS_SLOW : TICKS_FAST;
    localparam int CNT_W     = $clog2(TICKS_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST_SLOW = CNT_W'(TICKS_SLOW - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST_FAST = CNT_W'(TICKS_FAST - GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST_SLOW  = CNT_W'(TICKS_SLOW - 1);
    localparam logic [CNT_W-1:0] GAP_LAST_FAST  = CNT_W'(TICKS_FAST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, GAP, PAUSE} state_t;

    state_t             state_q, state_d, saved_q, saved_d, cur;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, hold_last, gap_last;
    logic               slow_q, slow_d;
    logic [NOTE_W-1:0]  song_note_q, song_note_d, note_out_q, note_out_d, key_code;
    logic               note_on_q, note_on_d, beat_q, beat_d, done_q, done_d;
    logic               advance, loading, active, preempt, key_any;

    assign rom_addr   = idx_q;
    assign note_out   = note_out_q;
    assign note_on    = note_on_q;
    assign beat_pulse = beat_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign active     = state_q inside {FETCH, LOAD, HOLD, GAP};
    assign key_any    = |key;
    assign hold_last  = slow_q ? HOLD_LAST_SLOW : HOLD_LAST_FAST;
    assign gap_last   = slow_q ? GAP_LAST_SLOW : GAP_LAST_FAST;

`ifdef KEY_PREEMPT_EN
    assign preempt = busy && key_any;
`else
    assign preempt = 1'b0;
`endif

    // Lowest pressed key wins: key[0] -> code 1 ... key[7] -> code 8.
    always_comb begin
        key_code = '0;
        for (int i = 7; i >= 0; i--) begin
            if (key[i]) key_code = NOTE_W'(i + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        slow_d  = slow_q;
        done_d  = 1'b0;
        loading = 1'b0;
        advance = 1'b0;
        cur     = state_q;
        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (pause && active) begin
            state_d = PAUSE;
            saved_d = state_q;
        end else if (!preempt) begin
            case (state_q)
                IDLE: if (play) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                PAUSE: if (play) begin
                    // ROM data for an interrupted LOAD is refetched rather than trusted.
                    if (saved_q == LOAD) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                    end else begin
                        advance = 1'b1;
                        cur     = saved_q;
                    end
                end
                default: advance = 1'b1;
            endcase
        end
        if (advance) begin
            case (cur)
                FETCH: begin
                    slow_d  = tempo;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LOAD;
                end
                LOAD: begin
                    loading = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == hold_last) ? GAP : HOLD;
                end
                GAP: begin
                    if (cnt_q == gap_last) begin
                        cnt_d = '0;
                        if (idx_q != LAST_IDX) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end else if (loop_en) begin
                            idx_d   = '0;
                            state_d = FETCH;
                        end else begin
                            idx_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = GAP;
                    end
                end
                default: ;
            endcase
        end
    end

    // song_note_q keeps the current song note so it can be restored after keyboard preemption.
    always_comb begin
        note_out_d  = note_out_q;
        note_on_d   = 1'b0;
        song_note_d = song_note_q;
        beat_d      = (state_d == FETCH) && (state_q != FETCH);
        if (stop) begin
            note_out_d  = '0;
            song_note_d = '0;
        end else if (((state_q == IDLE) && (state_d == IDLE)) || preempt) begin
            note_out_d = key_code;
            note_on_d  = key_any;
        end else if (state_q == IDLE) begin
            note_out_d  = '0;
            song_note_d = '0;
        end else begin
            if (loading) song_note_d = rom_note;
            note_out_d = song_note_d;
            note_on_d  = (state_d == HOLD) && (song_note_d != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            saved_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            slow_q      <= 1'b0;
            song_note_q <= '0;
            note_out_q  <= '0;
            note_on_q   <= 1'b0;
            beat_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            slow_q      <= slow_d;
            song_note_q <= song_note_d;
            note_out_q  <= note_out_d;
            note_on_q   <= note_on_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with a 3-note ROM {3,0,5}; expected per-cycle outputs
// are queued from the note timing and popped at each negedge.
module tb_song_sequencer;
    localparam int TS  = 10;
    localparam int TF  = 6;
    localparam int GAP = 1;
`ifdef KEY_PREEMPT_EN
    localparam int EXT = 3;
`else
    localparam int EXT = 0;
`endif

    logic       clk = 1'b0, rst = 1'b0;
    logic       play = 1'b0, pause = 1'b0, stop = 1'b0, tempo = 1'b0, loop_en = 1'b0;
    logic [7:0] key = '0;
    logic [6:0] rom_addr;
    logic [3:0] rom_note, note_out;
    logic       note_on, beat_pulse, busy, done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       beat;
        logic       on;
        logic       bsy;
        logic       dn;
        logic [3:0] out;
        bit         chk_out;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    song_sequencer #(
        .TICKS_SLOW(TS), .TICKS_FAST(TF), .GAP_TICKS(GAP),
        .SONG_LEN(3), .IDX_W(7), .NOTE_W(4)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .tempo(tempo), .loop_en(loop_en), .key(key), .rom_addr(rom_addr),
        .rom_note(rom_note), .note_out(note_out), .note_on(note_on),
        .beat_pulse(beat_pulse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (rom_addr)
            7'd0:    rom_note <= 4'd3;
            7'd1:    rom_note <= 4'd0;
            7'd2:    rom_note <= 4'd5;
            default: rom_note <= 4'd0;
        endcase
    end

    function automatic void push(logic b, logic o, logic bs, logic d, logic [3:0] out, bit chk);
        exp_t x;
        x.beat = b; x.on = o; x.bsy = bs; x.dn = d; x.out = out; x.chk_out = chk;
        exp_q.push_back(x);
    endfunction

    // One note of period t: beat at offset 0, previous note shown until LOAD completes,
    // sounding from offset 2 through t-GAP-1 unless it is a rest.
    function automatic void push_note(int note, int prev, int t, int o_from, int o_to);
        for (int o = o_from; o <= o_to; o++)
            push(o == 0, (o >= 2) && (o <= t - GAP - 1) && (note != 0), 1'b1, 1'b0,
                 4'((o < 2) ? prev : note), 1'b1);
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_play;
        play = 1'b1;
        next_cycle();
        play = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, note_on, beat_pulse, done, note_out, rom_addr} !== 15'd0)
            $display("FAIL reset_state busy=%b on=%b beat=%b done=%b out=%0d addr=%0d expected all 0",
                     busy, note_on, beat_pulse, done, note_out, rom_addr);
        if ({busy, note_on, beat_pulse, done, note_out, rom_addr} !== 15'd0) errors++;
        #1 rst = 1'b1;
        next_cycle();
        tempo = 1'b1; loop_en = 1'b0;
        pulse_play();
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (note_on !== 1'b1 || busy !== 1'b1 || note_out !== 4'd3) begin
            errors++;
            $display("FAIL pre_async on=%b busy=%b out=%0d expected on=1 busy=1 out=3", note_on, busy, note_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, note_on, note_out, rom_addr, beat_pulse, done} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset busy=%b on=%b out=%0d addr=%0d expected all 0", busy, note_on, note_out, rom_addr);
        end
        #1 rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_slow;
        exp_q.delete();
        tempo = 1'b1; loop_en = 1'b0;
        push_note(3, 0, TS, 0, TS - 1);
        push_note(0, 3, TS, 0, TS - 1);
        push_note(5, 0, TS, 0, TS - 1);
        push(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulse_play();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slow c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || (e.chk_out && note_out !== e.out)) begin
                    errors++;
                    $display("FAIL slow c=%0d beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             c, beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
            if (c == 31) begin
                checks++;
                if (rom_addr !== 7'd0) begin
                    errors++;
                    $display("FAIL slow_idx_end addr=%0d expected 0", rom_addr);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fast_loop;
        int seq[5] = '{3, 0, 5, 3, 0};
        exp_q.delete();
        tempo = 1'b0; loop_en = 1'b1;
        for (int n = 0; n < 5; n++) push_note(seq[n], (n == 0) ? 0 : seq[n - 1], TF, 0, TF - 1);
        push(1'b1, 1'b0, 1'b1, 1'b0, 4'(seq[4]), 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulse_play();
        for (int c = 0; c < 32; c++) begin
            stop = (c == 30);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fast_loop c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || (e.chk_out && note_out !== e.out)) begin
                    errors++;
                    $display("FAIL fast_loop c=%0d beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             c, beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
            next_cycle();
        end
        stop = 1'b0; loop_en = 1'b0;
    endtask

    task automatic test_pause;
        exp_q.delete();
        tempo = 1'b1; loop_en = 1'b0;
        push_note(3, 0, TS, 0, 5);
        repeat (10) push(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        push_note(3, 0, TS, 6, TS - 1);
        push_note(0, 3, TS, 0, TS - 1);
        push_note(5, 0, TS, 0, TS - 1);
        push(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulse_play();
        for (int c = 0; c < 42; c++) begin
            pause = (c == 5);
            play  = (c == 15);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pause c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || (e.chk_out && note_out !== e.out)) begin
                    errors++;
                    $display("FAIL pause c=%0d beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             c, beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
            next_cycle();
        end
        pause = 1'b0; play = 1'b0;
    endtask

    task automatic test_stop;
        exp_q.delete();
        tempo = 1'b1; loop_en = 1'b0;
        push_note(3, 0, TS, 0, TS - 1);
        push_note(0, 3, TS, 0, TS - 1);
        push_note(5, 0, TS, 0, 4);
        repeat (2) push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        push_note(3, 0, TS, 0, TS - 1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulse_play();
        for (int c = 0; c < 38; c++) begin
            stop = (c == 24) || (c == 36);
            play = (c == 26);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stop c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || (e.chk_out && note_out !== e.out)) begin
                    errors++;
                    $display("FAIL stop c=%0d beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             c, beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
            if (c == 22 || c == 25 || c == 27) begin
                checks++;
                if (rom_addr !== ((c == 22) ? 7'd2 : 7'd0)) begin
                    errors++;
                    $display("FAIL stop_idx c=%0d addr=%0d expected %0d", c, rom_addr, (c == 22) ? 2 : 0);
                end
            end
            next_cycle();
        end
        stop = 1'b0; play = 1'b0;
    endtask

    task automatic test_manual;
        logic [7:0] keys [6];
        logic [3:0] codes [6];
        keys  = '{8'b0010_0100, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h00};
        codes = '{4'd3, 4'd0, 4'd8, 4'd1, 4'd1, 4'd0};
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            key = keys[i];
            push(1'b0, keys[i] != 8'h00, 1'b0, 1'b0, codes[i], 1'b1);
            if (i == 0) begin
                #1;
                checks++;
                if (note_on !== 1'b0 || note_out !== 4'd0) begin
                    errors++;
                    $display("FAIL manual_latency on=%b out=%0d expected on=0 out=0 before the clock", note_on, note_out);
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL manual i=%0d scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || note_out !== e.out) begin
                    errors++;
                    $display("FAIL manual i=%0d key=%b beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             i, keys[i], beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
        end
        key = '0;
        next_cycle();
    endtask

    task automatic test_preempt;
        exp_q.delete();
        tempo = 1'b1; loop_en = 1'b0;
        push_note(3, 0, TS, 0, 4);
        repeat (EXT) push(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1);
        push_note(3, 0, TS, 5, TS - 1);
        push(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulse_play();
        for (int c = 0; c < TS + EXT + 2; c++) begin
            key  = (c >= 4 && c <= 6) ? 8'h80 : 8'h00;
            stop = (c == TS + EXT);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL preempt c=%0d scoreboard empty", c);
            end else begin
                e = exp_q.pop_front();
                if ({beat_pulse, note_on, busy, done} !== {e.beat, e.on, e.bsy, e.dn} || (e.chk_out && note_out !== e.out)) begin
                    errors++;
                    $display("FAIL preempt c=%0d beat/on/busy/done=%b%b%b%b out=%0d expected %b%b%b%b out=%0d",
                             c, beat_pulse, note_on, busy, done, note_out, e.beat, e.on, e.bsy, e.dn, e.out);
                end
            end
            next_cycle();
        end
        key = '0; stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slow();
        test_fast_loop();
        test_pause();
        test_stop();
        test_manual();
        test_preempt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
